// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - two-stage valid/ready bitwise reduction of NUM_IN operands with result counter
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              in_op,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        res_count
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;

    logic                    s1_valid;
    logic [NUM_IN*WIDTH-1:0] s1_data;
    logic [2:0]              s1_op;
    logic                    s2_load;
    logic [WIDTH-1:0]        and_r;
    logic [WIDTH-1:0]        or_r;
    logic [WIDTH-1:0]        xor_r;
    logic [WIDTH-1:0]        res;
    logic                    res_err;

    // S2 frees up when empty or being drained; S1 can take input when empty or moving up.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Bitwise reductions across all operands held in S1.
    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            and_r = and_r & s1_data[k*WIDTH +: WIDTH];
            or_r  = or_r  | s1_data[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ s1_data[k*WIDTH +: WIDTH];
        end
    end

    // Select the result for the S1 op code; the reserved code yields zero and flags an error.
    always_comb begin
        res     = '0;
        res_err = 1'b0;
        case (s1_op)
            OP_AND:  res = and_r;
            OP_OR:   res = or_r;
            OP_XOR:  res = xor_r;
            OP_NAND: res = ~and_r;
            OP_NOR:  res = ~or_r;
            OP_XNOR: res = ~xor_r;
            OP_PASS: res = s1_data[WIDTH-1:0];
            default: begin
                res     = '0;
                res_err = 1'b1;
            end
        endcase
    end

    // Stage 1: capture operands on input handshake, empty when contents move up with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_op    <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_op    <= in_op;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: register the result whenever it can load; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res;
                out_err  <= res_err;
            end
        end
    end

    // Wrapping count of output handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_count <= '0;
        end else if (out_valid && out_ready) begin
            res_count <= res_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - directed checks of logic_gate_pipe across four parameter sets
module tb_logic_gate_pipe;

    logic clk;
    logic rst;

    int pass_cnt;
    int total_cnt;

    // default instance: WIDTH 8, NUM_IN 2, CNT_W 16
    logic [15:0] d_in_data;
    logic [2:0]  d_in_op;
    logic        d_in_valid;
    logic        d_in_ready;
    logic [7:0]  d_out_data;
    logic        d_out_err;
    logic        d_out_valid;
    logic        d_out_ready;
    logic [15:0] d_res_count;

    // 1-bit instance
    logic [1:0]  b_in_data;
    logic [2:0]  b_in_op;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [0:0]  b_out_data;
    logic        b_out_err;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_res_count;

    // 4-operand instance
    logic [31:0] p_in_data;
    logic [2:0]  p_in_op;
    logic        p_in_valid;
    logic        p_in_ready;
    logic [7:0]  p_out_data;
    logic        p_out_err;
    logic        p_out_valid;
    logic        p_out_ready;
    logic [15:0] p_res_count;

    // 4-bit counter instance
    logic [15:0] c_in_data;
    logic [2:0]  c_in_op;
    logic        c_in_valid;
    logic        c_in_ready;
    logic [7:0]  c_out_data;
    logic        c_out_err;
    logic        c_out_valid;
    logic        c_out_ready;
    logic [3:0]  c_res_count;

    logic [7:0] ops_exp [0:7] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h00};
    logic [0:0] bit_exp [0:3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] bp_exp  [0:3] = '{8'h0A, 8'hAF, 8'hA5, 8'hAA};

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(16)) u_def (
        .clk(clk), .rst(rst), .in_data(d_in_data), .in_op(d_in_op), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .out_data(d_out_data), .out_err(d_out_err),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .res_count(d_res_count)
    );

    logic_gate_pipe #(.WIDTH(1), .NUM_IN(2), .CNT_W(16)) u_bit (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_op(b_in_op), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_err(b_out_err),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .res_count(b_res_count)
    );

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(16)) u_par (
        .clk(clk), .rst(rst), .in_data(p_in_data), .in_op(p_in_op), .in_valid(p_in_valid),
        .in_ready(p_in_ready), .out_data(p_out_data), .out_err(p_out_err),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .res_count(p_res_count)
    );

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(4)) u_cnt (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_op(c_in_op), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_err(c_out_err),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .res_count(c_res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        total_cnt++;
        if (d_out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", d_out_valid);
        else pass_cnt++;
        total_cnt++;
        if (d_out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", d_out_data);
        else pass_cnt++;
        total_cnt++;
        if (d_out_err !== 1'b0) $display("FAIL reset_out_err got %0b want 0", d_out_err);
        else pass_cnt++;
        total_cnt++;
        if (d_res_count !== 16'd0) $display("FAIL reset_res_count got %0d want 0", d_res_count);
        else pass_cnt++;
        total_cnt++;
        if (d_in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", d_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_all_ops();
        d_out_ready = 1'b1;
        d_in_data   = {8'h3C, 8'hF0};
        d_in_op     = 3'd0;
        d_in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c < 7) d_in_op = 3'(c + 1);
            else d_in_valid = 1'b0;
            if (c >= 1 && c <= 8) begin
                total_cnt++;
                if (d_out_valid !== 1'b1) $display("FAIL ops_valid op %0d got %0b want 1", c - 1, d_out_valid);
                else pass_cnt++;
                total_cnt++;
                if (d_out_data !== ops_exp[c-1]) $display("FAIL ops_data op %0d got %h want %h", c - 1, d_out_data, ops_exp[c-1]);
                else pass_cnt++;
                total_cnt++;
                if (d_out_err !== (c == 8)) $display("FAIL ops_err op %0d got %0b want %0b", c - 1, d_out_err, (c == 8));
                else pass_cnt++;
            end
            if (c == 9) begin
                total_cnt++;
                if (d_res_count !== 16'd8) $display("FAIL ops_res_count got %0d want 8", d_res_count);
                else pass_cnt++;
                total_cnt++;
                if (d_out_valid !== 1'b0) $display("FAIL ops_drained got %0b want 0", d_out_valid);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_one_bit_or();
        b_out_ready = 1'b1;
        b_in_op     = 3'd1;
        b_in_data   = 2'd0;
        b_in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c < 3) b_in_data = 2'(c + 1);
            else b_in_valid = 1'b0;
            if (c >= 1) begin
                total_cnt++;
                if (b_out_valid !== 1'b1) $display("FAIL bit_valid ab=%0d got %0b want 1", c - 1, b_out_valid);
                else pass_cnt++;
                total_cnt++;
                if (b_out_data !== bit_exp[c-1]) $display("FAIL bit_or ab=%0d got %0b want %0b", c - 1, b_out_data, bit_exp[c-1]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_parity();
        // bit0 set in 4 operands, bit1 in 3, bit2 in 2, bit3 in 1 -> odd parity on bits 1 and 3
        p_out_ready = 1'b1;
        p_in_op     = 3'd2;
        p_in_data   = {8'h0F, 8'h07, 8'h03, 8'h01};
        p_in_valid  = 1'b1;
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        total_cnt++;
        if (p_out_valid !== 1'b0) $display("FAIL par_early_valid got %0b want 0", p_out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (p_out_valid !== 1'b1) $display("FAIL par_valid got %0b want 1", p_out_valid);
        else pass_cnt++;
        total_cnt++;
        if (p_out_data !== 8'h0A) $display("FAIL par_data got %h want 0a", p_out_data);
        else pass_cnt++;
        total_cnt++;
        if (p_out_err !== 1'b0) $display("FAIL par_err got %0b want 0", p_out_err);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        d_out_ready = 1'b0;
        d_in_data   = {8'h0F, 8'hAA};
        d_in_op     = 3'd0;
        d_in_valid  = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (d_in_ready !== 1'b1) $display("FAIL bp_ready_one_held got %0b want 1", d_in_ready);
        else pass_cnt++;
        d_in_op = 3'd1;
        @(posedge clk); #1;
        d_in_op = 3'd2;
        for (int s = 0; s < 3; s++) begin
            total_cnt++;
            if (d_in_ready !== 1'b0) $display("FAIL bp_full_ready cycle %0d got %0b want 0", s, d_in_ready);
            else pass_cnt++;
            total_cnt++;
            if (d_out_valid !== 1'b1 || d_out_data !== bp_exp[0])
                $display("FAIL bp_stall_hold cycle %0d got %0b/%h want 1/%h", s, d_out_valid, d_out_data, bp_exp[0]);
            else pass_cnt++;
            if (s < 2) begin
                @(posedge clk); #1;
            end
        end
        d_out_ready = 1'b1;
        #1;
        total_cnt++;
        if (d_in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", d_in_ready);
        else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 0) d_in_op = 3'd6;
            if (c == 1) d_in_valid = 1'b0;
            if (c < 3) begin
                total_cnt++;
                if (d_out_valid !== 1'b1 || d_out_data !== bp_exp[c+1])
                    $display("FAIL bp_order idx %0d got %0b/%h want 1/%h", c + 1, d_out_valid, d_out_data, bp_exp[c+1]);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (d_out_valid !== 1'b0) $display("FAIL bp_no_dup got %0b want 0", d_out_valid);
                else pass_cnt++;
                total_cnt++;
                if (d_res_count !== 16'd12) $display("FAIL bp_res_count got %0d want 12", d_res_count);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_counter_wrap();
        c_out_ready = 1'b1;
        c_in_data   = {8'h55, 8'h33};
        c_in_op     = 3'd1;
        c_in_valid  = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk); #1;
            if (c == 17) c_in_valid = 1'b0;
            if (c == 17) begin
                total_cnt++;
                if (c_res_count !== 4'd15) $display("FAIL cnt_15 got %0d want 15", c_res_count);
                else pass_cnt++;
            end
            if (c == 18) begin
                total_cnt++;
                if (c_res_count !== 4'd0) $display("FAIL cnt_16_wrap got %0d want 0", c_res_count);
                else pass_cnt++;
            end
            if (c == 19) begin
                total_cnt++;
                if (c_res_count !== 4'd1) $display("FAIL cnt_17 got %0d want 1", c_res_count);
                else pass_cnt++;
                total_cnt++;
                if (c_out_data !== 8'h77) $display("FAIL cnt_data got %h want 77", c_out_data);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_async_reset();
        d_out_ready = 1'b0;
        d_in_data   = {8'h0F, 8'hAA};
        d_in_op     = 3'd1;
        d_in_valid  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        total_cnt++;
        if (d_in_ready !== 1'b0 || d_out_valid !== 1'b1)
            $display("FAIL arst_prefill got ready %0b valid %0b want 0 1", d_in_ready, d_out_valid);
        else pass_cnt++;
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (d_out_valid !== 1'b0) $display("FAIL arst_out_valid got %0b want 0", d_out_valid);
        else pass_cnt++;
        total_cnt++;
        if (d_out_data !== 8'h00) $display("FAIL arst_out_data got %h want 00", d_out_data);
        else pass_cnt++;
        total_cnt++;
        if (d_res_count !== 16'd0) $display("FAIL arst_res_count got %0d want 0", d_res_count);
        else pass_cnt++;
        total_cnt++;
        if (d_in_ready !== 1'b1) $display("FAIL arst_in_ready got %0b want 1", d_in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0)
            $display("FAIL arst_after_release got ready %0b valid %0b want 1 0", d_in_ready, d_out_valid);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst         = 1'b1;
        d_in_data   = '0; d_in_op = '0; d_in_valid = 1'b0; d_out_ready = 1'b1;
        b_in_data   = '0; b_in_op = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        p_in_data   = '0; p_in_op = '0; p_in_valid = 1'b0; p_out_ready = 1'b1;
        c_in_data   = '0; c_in_op = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_all_ops();
        test_one_bit_or();
        test_parity();
        test_back_pressure();
        test_counter_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
